// File: rtl/comparator_pkg.sv
// comparator_pkg: shared types and constants for the iterative comparator.
//   comp_state_t : controller state encoding (IDLE / RUN / DONE)
//   FLAG_*       : result flag encoding, packed as {greater, equal, lesser}
package comparator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } comp_state_t;

  localparam int unsigned FLAG_W = 3;

  localparam logic [FLAG_W-1:0] FLAG_NONE = 3'b000;
  localparam logic [FLAG_W-1:0] FLAG_GT   = 3'b100;
  localparam logic [FLAG_W-1:0] FLAG_EQ   = 3'b010;
  localparam logic [FLAG_W-1:0] FLAG_LT   = 3'b001;

  // Map a slice compare outcome onto the one-hot result encoding.
  function automatic logic [FLAG_W-1:0] flags_from_cmp(input logic gt, input logic lt);
    if (gt) begin
      return FLAG_GT;
    end else if (lt) begin
      return FLAG_LT;
    end
    return FLAG_EQ;
  endfunction

endpackage

// File: rtl/comparator_chunk.sv
// comparator_chunk: combinational unsigned compare of one CHUNK-bit slice.
//   a_i, b_i : slice operands
//   gt_c     : a_i > b_i
//   eq_c     : a_i == b_i
//   lt_c     : a_i < b_i
module comparator_chunk #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  output logic             gt_c,
  output logic             eq_c,
  output logic             lt_c
);

  assign gt_c = (a_i > b_i);
  assign eq_c = (a_i == b_i);
  assign lt_c = (a_i < b_i);

endmodule

// File: rtl/comparator_iterative.sv
// comparator_iterative: multi-cycle magnitude comparator, one CHUNK-bit slice
// per cycle, most significant slice first.
//   clk_i     : clock
//   rst_n_i   : asynchronous active-low reset
//   start_i   : request, accepted only while ready_o is high
//   signed_i  : 1 = two's-complement compare, 0 = unsigned (latched at accept)
//   A_i, B_i  : operands (latched at accept)
//   ready_o   : high while idle
//   done_o    : one-cycle pulse, result flags valid
//   greater_o, equal_o, lesser_o : result flags, held until next accept
// Build option COMP_EARLY_EXIT_EN: when defined the scan stops at the first
// differing slice; otherwise every slice is scanned and the first difference
// is remembered, giving a fixed latency.
module comparator_iterative
  import comparator_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  output logic             ready_o,
  output logic             done_o,
  output logic             greater_o,
  output logic             equal_o,
  output logic             lesser_o
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(NCHUNK - 1);

  comp_state_t       state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              signed_q, signed_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [FLAG_W-1:0] flags_q, flags_d;
  logic              done_q, done_d;
  logic              ready_q, ready_d;
`ifndef COMP_EARLY_EXIT_EN
  logic              found_q, found_d;
  logic [FLAG_W-1:0] res_q, res_d;
`endif

  logic [CHUNK-1:0]  a_sl_c, b_sl_c;
  logic [CHUNK-1:0]  a_cmp_c, b_cmp_c;
  logic              gt_c, eq_c, lt_c;

  // Select the current slice of each operand.
  always_comb begin
    a_sl_c = '0;
    b_sl_c = '0;
    for (int i = 0; i < int'(NCHUNK); i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_sl_c = a_q[i*CHUNK +: CHUNK];
        b_sl_c = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  // Flipping both sign bits maps two's-complement order onto unsigned order.
  always_comb begin
    a_cmp_c = a_sl_c;
    b_cmp_c = b_sl_c;
    if (signed_q && (idx_q == IDX_MSB)) begin
      a_cmp_c[CHUNK-1] = ~a_sl_c[CHUNK-1];
      b_cmp_c[CHUNK-1] = ~b_sl_c[CHUNK-1];
    end
  end

  comparator_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a_i  (a_cmp_c),
    .b_i  (b_cmp_c),
    .gt_c (gt_c),
    .eq_c (eq_c),
    .lt_c (lt_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    signed_d = signed_q;
    idx_d    = idx_q;
    flags_d  = flags_q;
`ifndef COMP_EARLY_EXIT_EN
    found_d  = found_q;
    res_d    = res_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          a_d      = A_i;
          b_d      = B_i;
          signed_d = signed_i;
          idx_d    = IDX_MSB;
          flags_d  = FLAG_NONE;
`ifndef COMP_EARLY_EXIT_EN
          found_d  = 1'b0;
          res_d    = FLAG_NONE;
`endif
          state_d  = RUN;
        end
      end

      RUN: begin
`ifdef COMP_EARLY_EXIT_EN
        if (!eq_c || (idx_q == '0)) begin
          flags_d = flags_from_cmp(gt_c, lt_c);
          state_d = DONE;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
`else
        // Keep the first difference; later slices cannot change the verdict.
        if (!found_q && !eq_c) begin
          found_d = 1'b1;
          res_d   = flags_from_cmp(gt_c, lt_c);
        end
        if (idx_q == '0) begin
          flags_d = found_q ? res_q : flags_from_cmp(gt_c, lt_c);
          state_d = DONE;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
`endif
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    done_d  = (state_d == DONE);
    ready_d = (state_d == IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      idx_q    <= '0;
      flags_q  <= FLAG_NONE;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
`ifndef COMP_EARLY_EXIT_EN
      found_q  <= 1'b0;
      res_q    <= FLAG_NONE;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      signed_q <= signed_d;
      idx_q    <= idx_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
`ifndef COMP_EARLY_EXIT_EN
      found_q  <= found_d;
      res_q    <= res_d;
`endif
    end
  end

  assign ready_o   = ready_q;
  assign done_o    = done_q;
  assign greater_o = flags_q[2];
  assign equal_o   = flags_q[1];
  assign lesser_o  = flags_q[0];

endmodule

// File: tb/tb_comparator_iterative.sv
// tb_comparator_iterative: transaction-level reference model plus per-cycle
// compare of ready/done/flags, directed vectors with literal expectations,
// and a randomized phase with random resets.
module tb_comparator_iterative;

  localparam int WIDTH  = 32;
  localparam int CHUNK  = 8;
  localparam int NCHUNK = WIDTH / CHUNK;

`ifdef COMP_EARLY_EXIT_EN
  localparam int LAT_29 = 2;
  localparam int LAT_32 = 3;
`else
  localparam int LAT_29 = 5;
  localparam int LAT_32 = 5;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic             sgn = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             ready_o, done_o, greater_o, equal_o, lesser_o;

  int tot = 0;
  int bad = 0;

  comparator_iterative dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .start_i   (start),
    .signed_i  (sgn),
    .A_i       (a),
    .B_i       (b),
    .ready_o   (ready_o),
    .done_o    (done_o),
    .greater_o (greater_o),
    .equal_o   (equal_o),
    .lesser_o  (lesser_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Number of slices examined: first differing slice from the top, or all.
  function automatic int exp_k(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
`ifdef COMP_EARLY_EXIT_EN
    for (int i = NCHUNK - 1; i >= 0; i--) begin
      if (((x >> (i * CHUNK)) & 32'hff) != ((y >> (i * CHUNK)) & 32'hff)) return NCHUNK - i;
    end
`endif
    return NCHUNK;
  endfunction

  // Expected {greater, equal, lesser} from plain arithmetic.
  function automatic logic [2:0] exp_f(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                       input logic s);
    if (s) begin
      if ($signed(x) > $signed(y)) return 3'b100;
      if ($signed(x) < $signed(y)) return 3'b001;
    end else begin
      if (x > y) return 3'b100;
      if (x < y) return 3'b001;
    end
    return 3'b010;
  endfunction

  // Model: t counts clock edges; a transaction accepted at edge a_t has its
  // done cycle right after edge a_t+k_t and the block idles from a_t+k_t+1.
  int         t = 0;
  int         a_t = 0;
  int         k_t = 0;
  bit         have = 1'b0;
  logic [2:0] f_t = 3'b000;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      have = 1'b0;
    end else begin
      t = t + 1;
      if (start && (!have || (t - 1 >= a_t + k_t + 1))) begin
        have = 1'b1;
        a_t  = t;
        k_t  = exp_k(a, b);
        f_t  = exp_f(a, b, sgn);
      end
    end
  end

  bit chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      logic       e_rdy, e_done;
      logic [2:0] e_fl;
      e_rdy  = !have || (t >= a_t + k_t + 1);
      e_done = have && (t == a_t + k_t);
      e_fl   = (have && (t >= a_t + k_t)) ? f_t : 3'b000;
      chk("ready_o", 32'(ready_o), 32'(e_rdy));
      chk("done_o", 32'(done_o), 32'(e_done));
      chk("flags", 32'({greater_o, equal_o, lesser_o}), 32'(e_fl));
    end
  end

  // Directed transaction: entered and left at posedge+2.
  task automatic run_dir(input string nm, input logic [31:0] x, input logic [31:0] y,
                         input logic s, input int e_lat, input logic [2:0] e_fl,
                         input bit poke);
    int lat;
    int ndone;
    lat = 0;
    ndone = 0;
    for (int i = 0; i < 20 && !ready_o; i++) begin
      @(posedge clk);
      #2;
    end
    chk({nm, "_ready"}, 32'(ready_o), 32'd1);
    a = x;
    b = y;
    sgn = s;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    sgn = ~s;
    for (int c = 1; c <= NCHUNK + 3; c++) begin
      if (poke && c == 2) start = 1'b1;
      if (poke && c == 3) start = 1'b0;
      @(negedge clk);
      if (done_o) begin
        ndone++;
        if (lat == 0) begin
          lat = c;
          chk({nm, "_flags"}, 32'({greater_o, equal_o, lesser_o}), 32'(e_fl));
        end
      end
      @(posedge clk);
      #2;
    end
    chk({nm, "_latency"}, 32'(lat), 32'(e_lat));
    chk({nm, "_ndone"}, 32'(ndone), 32'd1);
  endtask

  initial begin
    // Pin the model with hand-computed values.
    chk("model_f29", 32'(exp_f(32'h00000098, 32'hffffffd6, 1'b1)), 32'h4);
    chk("model_f30", 32'(exp_f(32'h00000098, 32'hffffffd6, 1'b0)), 32'h1);
    chk("model_k32", 32'(exp_k(32'h0fedcba9, 32'h0fe3cba9) + 1), 32'(LAT_32));

    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_ready", 32'(ready_o), 32'd1);
    chk("reset_flags", 32'({done_o, greater_o, equal_o, lesser_o}), 32'd0);
    @(posedge clk);
    #2;

    run_dir("r29", 32'h00000098, 32'hffffffd6, 1'b1, LAT_29, 3'b100, 1'b0);
    run_dir("r30", 32'h00000098, 32'hffffffd6, 1'b0, LAT_29, 3'b001, 1'b0);
    run_dir("r31s", 32'h0fedcba9, 32'h0fedcba9, 1'b1, 5, 3'b010, 1'b0);
    run_dir("r31u", 32'h0fedcba9, 32'h0fedcba9, 1'b0, 5, 3'b010, 1'b0);
    run_dir("r32", 32'h0fedcba9, 32'h0fe3cba9, 1'b1, LAT_32, 3'b100, 1'b0);
    run_dir("r33", 32'hffffff00, 32'hffffffe5, 1'b1, 5, 3'b001, 1'b1);

    // Reset in the middle of a running compare.
    a = 32'h0fedcba9;
    b = 32'h0fedcba9;
    sgn = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int c = 0; c < NCHUNK + 2; c++) begin
      @(negedge clk);
      chk("r34_no_done", 32'(done_o), 32'd0);
      chk("r34_flags", 32'({greater_o, equal_o, lesser_o}), 32'd0);
      chk("r34_ready", 32'(ready_o), 32'd1);
      @(posedge clk);
      #2;
    end
    run_dir("r34", 32'h00000001, 32'h00000000, 1'b0, 5, 3'b100, 1'b0);

    // Random traffic: varied slice-difference positions, held starts, resets.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] x, y;
      x = $urandom;
      y = x;
      for (int i = 0; i < NCHUNK; i++) begin
        if ($urandom_range(0, 2) == 0) y[i*CHUNK +: CHUNK] = 8'($urandom);
      end
      if ($urandom_range(0, 1) == 0) begin
        a = x;
        b = y;
      end else begin
        a = y;
        b = x;
      end
      sgn = 1'($urandom_range(0, 1));
      start = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 299) != 0);
      @(posedge clk);
      #2;
    end
    rst_n = 1'b1;
    start = 1'b0;
    repeat (NCHUNK + 3) begin
      @(posedge clk);
      #2;
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
